// File: rtl/apb_regfile_slave_pkg.sv
// Shared types, default widths and the byte-lane merge helper for the APB
// register-file completer.
package apb_regfile_slave_pkg;

  localparam int unsigned APB_DATA_WIDTH = 32;
  localparam int unsigned APB_ADDR_WIDTH = 8;
  localparam int unsigned WAIT_CNT_W     = 4;

  // The merge helper is written once at the widest supported bus; callers
  // zero-extend their operands and truncate the result back.
  localparam int unsigned MAX_DATA_WIDTH = 256;
  localparam int unsigned MAX_STRB_WIDTH = MAX_DATA_WIDTH / 8;

  typedef enum logic {
    IDLE,
    ACCESS
  } apb_state_e;

  function automatic logic [MAX_DATA_WIDTH-1:0] apply_strb(
    input logic [MAX_DATA_WIDTH-1:0] old_word,
    input logic [MAX_DATA_WIDTH-1:0] wdata,
    input logic [MAX_STRB_WIDTH-1:0] strb
  );
    logic [MAX_DATA_WIDTH-1:0] res;
    res = old_word;
    for (int b = 0; b < MAX_STRB_WIDTH; b++) begin
      if (strb[b]) res[b*8 +: 8] = wdata[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/apb_regfile_slave_if.sv
// APB4 bus bundle between the bridge (master) and a completer (slave).
interface apb_regfile_slave_if
  import apb_regfile_slave_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = APB_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = APB_ADDR_WIDTH
);

  logic                    PSEL;
  logic                    PENABLE;
  logic                    PWRITE;
  logic [ADDR_WIDTH-1:0]   PADDR;
  logic [DATA_WIDTH-1:0]   PWDATA;
  logic [DATA_WIDTH/8-1:0] PSTRB;
  logic [DATA_WIDTH-1:0]   PRDATA;
  logic                    PREADY;
  logic                    PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb_regfile_slave_wait_ctr.sv
// Loadable down-counter that flags when an APB access has served its wait
// states; shared by APB completers that insert PREADY wait cycles.
module apb_regfile_slave_wait_ctr
  import apb_regfile_slave_pkg::*;
#(
  parameter int unsigned WIDTH = WAIT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // NOTE: every always_comb output gets a default first so no path can infer
  // a latch; blocking (=) here, non-blocking (<=) only in the flop process.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/apb_regfile_slave.sv
// APB4 completer terminating the bus into NUM_REGS word registers with byte
// strobes, programmable wait states, error responses and read-only status slots.
module apb_regfile_slave
  import apb_regfile_slave_pkg::*;
#(
  parameter int unsigned          DATA_WIDTH  = APB_DATA_WIDTH,
  parameter int unsigned          ADDR_WIDTH  = APB_ADDR_WIDTH,
  parameter int unsigned          NUM_REGS    = 8,
  parameter int unsigned          WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0]  RO_MASK     = NUM_REGS'(128),
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                           PCLK,
  input  logic                           PRESET,
  apb_regfile_slave_if.slave             bus,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] status_i,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  apb_state_e            state_q, state_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  logic [ADDR_WIDTH-3:0] idx;
  logic [IDX_W-1:0]      idx_sel;
  logic                  in_range, derr, aerr;
  logic [DATA_WIDTH-1:0] rd_val;
  logic                  ctr_load, ctr_dec, ctr_zero;
  logic                  pready, pslverr;

  assign idx      = bus.PADDR[ADDR_WIDTH-1:2];
  assign idx_sel  = idx[IDX_W-1:0];
  assign in_range = (32'(idx) < NUM_REGS);
  assign derr     = !in_range || (bus.PADDR[1:0] != 2'b00);
  assign aerr     = bus.PWRITE && in_range && RO_MASK[idx_sel];

  // Read data captured in the setup phase; writes and decode errors return 0.
  always_comb begin
    rd_val = '0;
    if (!derr && !bus.PWRITE) begin
      if (RO_MASK[idx_sel]) rd_val = status_i[32'(idx_sel)*DATA_WIDTH +: DATA_WIDTH];
      else                  rd_val = regs_q[idx_sel];
    end
  end

  apb_regfile_slave_wait_ctr #(
    .WIDTH (WAIT_CNT_W)
  ) u_wait_ctr (
    .clk        (PCLK),
    .rst        (PRESET),
    .load_i     (ctr_load),
    .load_val_i (WAIT_CNT_W'(WAIT_STATES)),
    .dec_i      (ctr_dec),
    .zero_o     (ctr_zero)
  );

  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    prdata_d = prdata_q;
    regs_d   = regs_q;
    ctr_load = 1'b0;
    ctr_dec  = 1'b0;
    pready   = 1'b0;
    pslverr  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.PSEL && !bus.PENABLE) begin
          state_d  = ACCESS;
          ctr_load = 1'b1;
          err_d    = derr || aerr;
          prdata_d = rd_val;
        end else if (bus.PSEL && bus.PENABLE) begin
          // Access phase without a setup phase: flag it, write nothing.
          pready  = 1'b1;
          pslverr = 1'b1;
        end
      end
      ACCESS: begin
        if (!bus.PSEL) begin
          state_d = IDLE;
        end else if (bus.PENABLE) begin
          if (ctr_zero) begin
            pready  = 1'b1;
            pslverr = err_q;
            state_d = IDLE;
            if (bus.PWRITE && !err_q) begin
              regs_d[idx_sel] = DATA_WIDTH'(apply_strb(MAX_DATA_WIDTH'(regs_q[idx_sel]),
                                                       MAX_DATA_WIDTH'(bus.PWDATA),
                                                       MAX_STRB_WIDTH'(bus.PSTRB)));
            end
          end else begin
            ctr_dec = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q  <= IDLE;
      err_q    <= 1'b0;
      prdata_q <= '0;
      // NOTE: the bank is a handful of configuration flops, not a RAM macro,
      // so every word gets a defined reset value.
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
    end else begin
      state_q  <= state_d;
      err_q    <= err_d;
      prdata_q <= prdata_d;
      regs_q   <= regs_d;
    end
  end

  always_comb begin
    regs_o = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (!RO_MASK[i]) regs_o[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    end
  end

  assign bus.PRDATA  = prdata_q;
  assign bus.PREADY  = pready;
  assign bus.PSLVERR = pslverr;

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Scoreboard bench: two completers (0 and 3 wait states) driven by directed and
// random APB transfers, checked against a word-array model of the register map.
module tb_apb_regfile_slave;

  localparam int DW  = 32;
  localparam int AW  = 8;
  localparam int NR  = 8;
  localparam int SW  = DW / 8;
  localparam int WS0 = 0;
  localparam int WS1 = 3;
  localparam logic [NR-1:0] RO      = 8'h80;
  localparam logic [DW-1:0] RST_VAL = '0;

  typedef struct {
    string         name;
    logic          chk_data;
    logic [DW-1:0] data;
    logic          err;
    int            waits;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             preset  [2];
  logic             psel    [2];
  logic             penable [2];
  logic             pwrite  [2];
  logic [AW-1:0]    paddr   [2];
  logic [DW-1:0]    pwdata  [2];
  logic [SW-1:0]    pstrb   [2];
  logic [DW-1:0]    prdata  [2];
  logic             pready  [2];
  logic             pslverr [2];
  logic [NR*DW-1:0] status  [2];
  logic [NR*DW-1:0] regs_o  [2];

  apb_regfile_slave_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_if0 ();
  apb_regfile_slave_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_if1 ();

  assign u_if0.PSEL    = psel[0];
  assign u_if0.PENABLE = penable[0];
  assign u_if0.PWRITE  = pwrite[0];
  assign u_if0.PADDR   = paddr[0];
  assign u_if0.PWDATA  = pwdata[0];
  assign u_if0.PSTRB   = pstrb[0];
  assign prdata[0]     = u_if0.PRDATA;
  assign pready[0]     = u_if0.PREADY;
  assign pslverr[0]    = u_if0.PSLVERR;

  assign u_if1.PSEL    = psel[1];
  assign u_if1.PENABLE = penable[1];
  assign u_if1.PWRITE  = pwrite[1];
  assign u_if1.PADDR   = paddr[1];
  assign u_if1.PWDATA  = pwdata[1];
  assign u_if1.PSTRB   = pstrb[1];
  assign prdata[1]     = u_if1.PRDATA;
  assign pready[1]     = u_if1.PREADY;
  assign pslverr[1]    = u_if1.PSLVERR;

  apb_regfile_slave #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .WAIT_STATES(WS0),
    .RO_MASK(RO), .RESET_VAL(RST_VAL)
  ) u_dut0 (
    .PCLK(clk), .PRESET(preset[0]), .bus(u_if0), .status_i(status[0]), .regs_o(regs_o[0])
  );

  apb_regfile_slave #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .WAIT_STATES(WS1),
    .RO_MASK(RO), .RESET_VAL(RST_VAL)
  ) u_dut1 (
    .PCLK(clk), .PRESET(preset[1]), .bus(u_if1), .status_i(status[1]), .regs_o(regs_o[1])
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  int   acc_cnt [2] = '{0, 0};
  bit   scramble = 1'b0;
  exp_t sb0 [$];
  exp_t sb1 [$];
  logic [DW-1:0] mreg [2][NR];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic int ws_of(input int d);
    return (d == 0) ? WS0 : WS1;
  endfunction

  function automatic void sb_push(input int d, input exp_t e);
    if (d == 0) sb0.push_back(e);
    else        sb1.push_back(e);
  endfunction

  function automatic void model_reset(input int d);
    for (int i = 0; i < NR; i++) mreg[d][i] = RST_VAL;
  endfunction

  // Monitor: every PREADY cycle consumes one expected response.
  task automatic mon_step(input int d);
    exp_t e;
    bit   have;
    if (preset[d] === 1'b1) begin
      acc_cnt[d] = 0;
      return;
    end
    if (pslverr[d] === 1'b1 && pready[d] !== 1'b1)
      check($sformatf("pslverr_unqualified%0d", d), 64'(pready[d]), 64'd1);
    if (pready[d] === 1'b1) begin
      have = 1'b0;
      if (d == 0 && sb0.size() > 0) begin e = sb0.pop_front(); have = 1'b1; end
      else if (d == 1 && sb1.size() > 0) begin e = sb1.pop_front(); have = 1'b1; end
      if (!have) begin
        check($sformatf("unexpected_ready%0d", d), 64'(pready[d]), 64'd0);
      end else begin
        check({e.name, "_err"}, 64'(pslverr[d]), 64'(e.err));
        check({e.name, "_waits"}, 64'(acc_cnt[d]), 64'(e.waits));
        if (e.chk_data) check({e.name, "_rdata"}, 64'(prdata[d]), 64'(e.data));
      end
      acc_cnt[d] = 0;
    end else if (psel[d] === 1'b1 && penable[d] === 1'b1) begin
      acc_cnt[d]++;
    end else if (psel[d] !== 1'b1) begin
      acc_cnt[d] = 0;
    end
  endtask

  always @(negedge clk) begin
    mon_step(0);
    mon_step(1);
  end

  task automatic wait_ready(input int d);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (pready[d] === 1'b1) return;
    end
    check($sformatf("timeout%0d", d), 64'(pready[d]), 64'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_setup(input int d, input logic wr, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata, input logic [SW-1:0] strb);
    psel[d]    = 1'b1;
    penable[d] = 1'b0;
    pwrite[d]  = wr;
    paddr[d]   = addr;
    pwdata[d]  = wdata;
    pstrb[d]   = strb;
  endtask

  // Called at posedge+1; leaves the bus idle at posedge+1 after completion.
  task automatic xfer(input int d, input logic wr, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wdata, input logic [SW-1:0] strb, input string name);
    exp_t e;
    int   idx;
    logic derr, aerr;
    idx  = int'(addr) / 4;
    derr = (idx >= NR) || (addr % 4 != 0);
    aerr = wr && !derr && RO[idx];
    e.name     = $sformatf("%s%0d", name, d);
    e.chk_data = 1'b1;
    e.err      = derr || aerr;
    e.waits    = ws_of(d);
    if (derr || wr)   e.data = '0;
    else if (RO[idx]) e.data = status[d][idx*DW +: DW];
    else              e.data = mreg[d][idx];
    if (wr && !e.err)
      for (int b = 0; b < SW; b++)
        if (strb[b]) mreg[d][idx][b*8 +: 8] = wdata[b*8 +: 8];
    drive_setup(d, wr, addr, wdata, strb);
    sb_push(d, e);
    @(posedge clk); #1;
    penable[d] = 1'b1;
    if (scramble)
      for (int i = 0; i < NR; i++) status[d][i*DW +: DW] = $urandom();
    wait_ready(d);
    @(posedge clk); #1;
    psel[d]    = 1'b0;
    penable[d] = 1'b0;
  endtask

  task automatic viol(input int d);
    exp_t e;
    e.name     = $sformatf("viol%0d", d);
    e.chk_data = 1'b0;
    e.data     = '0;
    e.err      = 1'b1;
    e.waits    = 0;
    psel[d]    = 1'b1;
    penable[d] = 1'b1;
    pwrite[d]  = 1'b1;
    paddr[d]   = '0;
    pwdata[d]  = $urandom();
    pstrb[d]   = '1;
    sb_push(d, e);
    @(posedge clk); #1;
    psel[d]    = 1'b0;
    penable[d] = 1'b0;
  endtask

  task automatic abort_x(input int d, input logic wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input int n_acc);
    drive_setup(d, wr, addr, wdata, '1);
    @(posedge clk); #1;
    penable[d] = 1'b1;
    repeat (n_acc) @(posedge clk);
    #1;
    psel[d]    = 1'b0;
    penable[d] = 1'b0;
    idle(1);
  endtask

  task automatic check_regs(input int d, input string name);
    for (int i = 0; i < NR; i++)
      check($sformatf("%s%0d_reg%0d", name, d, i), 64'(regs_o[d][i*DW +: DW]),
            RO[i] ? 64'd0 : 64'(mreg[d][i]));
  endtask

  task automatic check_idle_outputs(input int d, input string name);
    check($sformatf("%s%0d_pready", name, d), 64'(pready[d]), 64'd0);
    check($sformatf("%s%0d_pslverr", name, d), 64'(pslverr[d]), 64'd0);
    check($sformatf("%s%0d_prdata", name, d), 64'(prdata[d]), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish before 500000 ns");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] a;
    int            r;
    for (int d = 0; d < 2; d++) begin
      preset[d] = 1'b1;
      psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
      paddr[d] = '0; pwdata[d] = '0; pstrb[d] = '0;
      for (int i = 0; i < NR; i++) status[d][i*DW +: DW] = $urandom();
      status[d][7*DW +: DW] = 32'hCAFE_F00D;
      model_reset(d);
    end
    repeat (2) @(posedge clk);
    #1;
    preset[0] = 1'b0;
    preset[1] = 1'b0;
    @(negedge clk);
    check_idle_outputs(0, "reset");
    check_idle_outputs(1, "reset");
    @(posedge clk); #1;

    // Zero-wait completer: read every slot back to back.
    for (int i = 0; i < NR; i++) xfer(0, 1'b0, AW'(i * 4), '0, '0, $sformatf("rd_all%0d_", i));

    // Byte-lane write.
    xfer(0, 1'b1, 8'h04, 32'h1111_1111, 4'hF, "wr_init");
    xfer(0, 1'b1, 8'h04, 32'hDEAD_BEEF, 4'b0101, "wr_strb");
    xfer(0, 1'b0, 8'h04, '0, '0, "rd_strb");
    check("strb_regs_o", 64'(regs_o[0][63:32]), 64'h11AD_11EF);

    // Error responses, empty strobe, protocol violation.
    xfer(0, 1'b1, 8'h1C, 32'h1234_5678, 4'hF, "wr_ro");
    xfer(0, 1'b0, 8'h20, '0, '0, "rd_oor");
    xfer(0, 1'b0, 8'h02, '0, '0, "rd_misal");
    xfer(0, 1'b1, 8'h09, 32'hFFFF_FFFF, 4'hF, "wr_misal");
    xfer(0, 1'b1, 8'h08, 32'hFFFF_FFFF, 4'h0, "wr_nostrb");
    xfer(0, 1'b0, 8'h1C, '0, '0, "rd_ro");
    viol(0);
    idle(1);
    check_regs(0, "after_err");

    // Three-wait completer: latency, reset mid-write, master abort.
    xfer(1, 1'b0, 8'h00, '0, '0, "rd_ws3");
    xfer(1, 1'b1, 8'h08, 32'hA5A5_5A5B, 4'hF, "wr_pre");
    drive_setup(1, 1'b1, 8'h08, 32'h0F0F_0F0F, 4'hF);
    @(posedge clk); #1;
    penable[1] = 1'b1;
    @(posedge clk); #1;
    preset[1] = 1'b1;
    @(posedge clk); #1;
    preset[1]  = 1'b0;
    psel[1]    = 1'b0;
    penable[1] = 1'b0;
    model_reset(1);
    @(negedge clk);
    check_idle_outputs(1, "midrst");
    @(posedge clk); #1;
    check("midrst_reg2", 64'(regs_o[1][95:64]), 64'(RST_VAL));
    xfer(1, 1'b0, 8'h08, '0, '0, "rd_after_rst");

    xfer(1, 1'b1, 8'h0C, 32'h1357_9BDF, 4'hF, "wr_pre_abort");
    abort_x(1, 1'b1, 8'h0C, 32'hFFFF_0000, 2);
    abort_x(1, 1'b0, 8'h0C, '0, 1);
    xfer(1, 1'b0, 8'h0C, '0, '0, "rd_after_abort");
    viol(1);
    idle(1);
    check_regs(1, "after_abort");

    // Randomised traffic with status inputs changing during access phases.
    scramble = 1'b1;
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 60; n++) begin
        r = $urandom_range(0, 11);
        if (r < 10)       a = AW'(r * 4);
        else if (r == 10) a = AW'($urandom_range(0, 7) * 4 + $urandom_range(1, 3));
        else              a = 8'hFC;
        xfer(d, 1'($urandom_range(0, 1)), a, $urandom(), SW'($urandom_range(0, 15)),
             $sformatf("rnd%0d_", n));
        if ($urandom_range(0, 3) == 0) idle(1);
      end
      check_regs(d, "after_rnd");
    end

    idle(3);
    check("pending0", 64'(sb0.size()), 64'd0);
    check("pending1", 64'(sb1.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
